fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 16'h0000: PC loaded on reset.
REQ-002 Parameter HALT_OPC, 5'b00000: instruction[15:11] value decoded as HALT.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  instruction-memory read request.
REQ-006 imem_addr  out  16  read address, equal to internal PC.
REQ-007 imem_rdata  in  16  read data, valid when imem_ack=1.
REQ-008 imem_ack  in  1  read complete; legal only while imem_req=1.
REQ-009 stall_in  in  1  downstream (IF/ID) cannot accept a new instruction.
REQ-010 redirect_valid  in  1  branch/jump taken; single-cycle pulse.
REQ-011 redirect_pc  in  16  redirect target.
REQ-012 instruction  out  16  fetched instruction, registered.
REQ-013 pc_out  out  16  fetch address + 2, registered.
REQ-014 done_fetch  out  1  instruction/pc_out valid for IF/ID this cycle.
REQ-015 stall_fetch  out  1  request outstanding, no ack this cycle.
REQ-016 halt_fetch  out  1  delivered instruction is HALT.
REQ-017 err_fetch  out  1  misaligned redirect (REQ-038 only).

Function
REQ-018 States FETCH, HOLD, HALT; reset state FETCH.
REQ-019 FETCH: imem_req=1, imem_addr=PC held stable until imem_ack.
REQ-020 imem_ack in same cycle as request assertion (zero-wait) is legal.
REQ-021 stall_fetch = (state==FETCH) & ~imem_ack, combinational.
REQ-022 FETCH, ack, no squash: instruction<=imem_rdata, pc_out<=PC+2, PC<=PC+2, mod 2^16 (16'hFFFE wraps to 16'h0000).
REQ-023 Capture with stall_in=0: done_fetch=1 next cycle only, single pulse.
REQ-024 Capture with stall_in=1: go HOLD, done_fetch=0, imem_req=0; leave HOLD first cycle stall_in=0, done_fetch=1 that next cycle.
REQ-025 Captured instruction with [15:11]==HALT_OPC: halt_fetch=1 with its done_fetch; next state HALT (via HOLD if stalled).
REQ-026 HALT: imem_req=0, done_fetch=0, outputs held; exit only via redirect or reset.
REQ-027 redirect_valid highest priority in all states: PC<=redirect_pc; captured/HOLD data dropped; done_fetch, halt_fetch not asserted for it.
REQ-028 Redirect while request outstanding, no ack: set squash; imem_req/imem_addr held (memory uncancellable); returning ack discarded; next request to redirect_pc.
REQ-029 Redirect coincident with ack: data discarded, no squash set, next request to redirect_pc next cycle.
REQ-030 Redirect while squash pending overwrites target; single squash only.
REQ-031 Redirect in HOLD or HALT: go FETCH, request redirect_pc next cycle.
REQ-032 stall_in does not abort an outstanding request.

Reset
REQ-033 rst_n=0 immediately forces PC=RESET_PC, state FETCH, squash=0, imem_req=0 (async), instruction=16'h0800 (NOP), pc_out=0, done_fetch=0, halt_fetch=0, err_fetch=0.
REQ-034 Mid-transaction reset abandons request; no response consumed after.
REQ-035 First request: first rising clk edge after rst_n deasserts.

Configuration
REQ-036 Macro FETCH_ALIGN_CHECK_EN.
REQ-037 Undefined: redirect_pc[0] ignored (forced 0); err_fetch tied 0.
REQ-038 Defined: redirect with redirect_pc[0]=1 sets err_fetch=1 (sticky until reset), enters HALT, no request issued.

Verification
REQ-039 Reset, ack zero-wait every cycle, stall_in=0 -> addrs 0000,0002,0004; done_fetch every cycle, pc_out 0002,0004,0006.
REQ-040 Ack 3 cycles late -> stall_fetch=1 for 3 cycles, imem_addr constant, one done_fetch pulse.
REQ-041 Redirect to 16'h0040 mid-wait, ack 2 cycles later with 16'h1234 -> no done_fetch for 1234, next imem_addr=0040.
REQ-042 imem_rdata=16'h0000 with stall_in=1 for 2 cycles -> HOLD, then done_fetch+halt_fetch one cycle, imem_req stays 0; redirect 0010 -> fetch resumes at 0010.
REQ-043 PC=16'hFFFE ack -> pc_out=16'h0000, next imem_addr=0000.
REQ-044 FETCH_ALIGN_CHECK_EN defined, redirect 16'h0021 -> err_fetch=1, imem_req=0; undefined -> imem_addr=0020.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus between fetch_ctrl (master) and the memory (slave).
interface fetch_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding read, IF/ID hold, HALT decode, redirect squash.
// Optional FETCH_ALIGN_CHECK_EN: odd redirect targets raise sticky err_fetch and halt.
//
// state | meaning
// FETCH | read request to PC outstanding (or about to be issued after reset)
// HOLD  | instruction captured, waiting for IF/ID to drop stall_in
// HALT  | HALT delivered or misaligned redirect; idle until redirect/reset
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [4:0]  HALT_OPC = 5'b00000
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_ctrl_if.master      imem,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [15:0]       redirect_pc,
  output logic [15:0]       instruction,
  output logic [15:0]       pc_out,
  output logic              done_fetch,
  output logic              stall_fetch,
  output logic              halt_fetch,
  output logic              err_fetch
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] sq_addr, sq_addr_n;
  logic        squash, squash_n;
  logic        req_en;
  logic [15:0] instr_n, pc_out_n;
  logic        done_n, halt_n;
  logic        ack_v, misaligned;
  logic [15:0] target;

  // A squashed read keeps the bus stable on its original address until the memory answers.
  assign imem.imem_req  = req_en & ((state == FETCH) | squash);
  assign imem.imem_addr = squash ? sq_addr : pc;
  assign stall_fetch    = (state == FETCH) & ~imem.imem_ack;
  assign ack_v          = imem.imem_req & imem.imem_ack;
  assign target         = redirect_pc & 16'hFFFE;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = redirect_pc[0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    sq_addr_n = sq_addr;
    squash_n  = squash;
    instr_n   = instruction;
    pc_out_n  = pc_out;
    done_n    = 1'b0;
    halt_n    = 1'b0;

    if (squash && ack_v)
      squash_n = 1'b0;

    if (redirect_valid) begin
      pc_n    = target;
      state_n = misaligned ? HALT : FETCH;
      if (imem.imem_req && !imem.imem_ack) begin
        squash_n  = 1'b1;
        sq_addr_n = squash ? sq_addr : pc;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ack_v && !squash) begin
            instr_n  = imem.imem_rdata;
            pc_out_n = pc + 16'd2;
            pc_n     = pc + 16'd2;
            if (stall_in) begin
              state_n = HOLD;
            end else begin
              done_n  = 1'b1;
              halt_n  = (imem.imem_rdata[15:11] == HALT_OPC);
              state_n = halt_n ? HALT : FETCH;
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            done_n  = 1'b1;
            halt_n  = (instruction[15:11] == HALT_OPC);
            state_n = halt_n ? HALT : FETCH;
          end
        end
        default: state_n = HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      sq_addr     <= RESET_PC;
      squash      <= 1'b0;
      req_en      <= 1'b0;
      instruction <= 16'h0800;
      pc_out      <= 16'h0000;
      done_fetch  <= 1'b0;
      halt_fetch  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      sq_addr     <= sq_addr_n;
      squash      <= squash_n;
      req_en      <= 1'b1;
      instruction <= instr_n;
      pc_out      <= pc_out_n;
      done_fetch  <= done_n;
      halt_fetch  <= halt_n;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (redirect_valid && misaligned)
      err_q <= 1'b1;
  end
  assign err_fetch = err_q;
`else
  assign err_fetch = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes expected deliveries, monitor pops on done_fetch.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instruction, pc_out;
  logic        done_fetch, stall_fetch, halt_fetch, err_fetch;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem(bus.master),
    .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .pc_out(pc_out), .done_fetch(done_fetch),
    .stall_fetch(stall_fetch), .halt_fetch(halt_fetch), .err_fetch(err_fetch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every done_fetch must match the oldest expected delivery.
  always @(negedge clk) begin
    #2;
    if (rst_n && done_fetch) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got instr %h pc_out %h expected no delivery at %0t",
                 instruction, pc_out, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instruction", instruction, e.instr);
        chk("pc_out", pc_out, e.pc);
        chk("halt_fetch", {15'd0, halt_fetch}, {15'd0, e.halt});
      end
    end
  end

  task automatic step(input logic ack, input logic [15:0] rdata, input logic stl,
                      input logic rv, input logic [15:0] rpc);
    @(negedge clk);
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
    stall_in       = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic deliver(input logic [15:0] addr, input logic [15:0] rdata, input logic stl);
    step(1'b1, rdata, stl, 1'b0, 16'h0000);
    chk("imem_addr", bus.imem_addr, addr);
    chk("imem_req", {15'd0, bus.imem_req}, 16'd1);
    exp_q.push_back('{rdata, addr + 16'd2, rdata[15:11] == 5'b00000});
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rst_instr", instruction, 16'h0800);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_done", {15'd0, done_fetch}, 16'd0);
    chk("rst_err", {15'd0, err_fetch}, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("req_before_edge", {15'd0, bus.imem_req}, 16'd0);

    // Zero-wait streaming
    for (int i = 0; i < 3; i++) begin
      deliver(16'(2 * i), 16'h1000 | 16'(i), 1'b0);
      chk("stall_zero_wait", {15'd0, stall_fetch}, 16'd0);
    end

    // Ack three cycles late
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("late_stall", {15'd0, stall_fetch}, 16'd1);
      chk("late_addr", bus.imem_addr, 16'h0006);
    end
    deliver(16'h0006, 16'h2345, 1'b0);
    chk("late_ack_stall", {15'd0, stall_fetch}, 16'd0);

    // Redirect mid-wait, late ack squashed
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040);
    idle();
    chk("squash_addr_held", bus.imem_addr, 16'h0008);
    chk("squash_req_held", {15'd0, bus.imem_req}, 16'd1);
    step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    chk("squash_ack_addr", bus.imem_addr, 16'h0008);
    idle();
    chk("after_squash_addr", bus.imem_addr, 16'h0040);
    deliver(16'h0040, 16'h3000, 1'b0);

    // HALT captured under stall
    deliver(16'h0042, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    chk("hold_req", {15'd0, bus.imem_req}, 16'd0);
    chk("hold_stall_fetch", {15'd0, stall_fetch}, 16'd0);
    idle();
    chk("hold_release_req", {15'd0, bus.imem_req}, 16'd0);
    idle();
    chk("halt_req", {15'd0, bus.imem_req}, 16'd0);
    idle();
    chk("halt_done", {15'd0, done_fetch}, 16'd0);
    chk("halt_req2", {15'd0, bus.imem_req}, 16'd0);
    chk("halt_instr_held", instruction, 16'h0000);

    // Redirect out of HALT
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010);
    deliver(16'h0010, 16'h1111, 1'b0);

    // Redirect coincident with ack
    step(1'b1, 16'h4444, 1'b0, 1'b1, 16'h0080);
    idle();
    chk("coinc_addr", bus.imem_addr, 16'h0080);
    chk("coinc_req", {15'd0, bus.imem_req}, 16'd1);
    deliver(16'h0080, 16'h5555, 1'b0);

    // PC wrap at 16'hFFFE
    step(1'b1, 16'hAAAA, 1'b0, 1'b1, 16'hFFFE);
    deliver(16'hFFFE, 16'h6666, 1'b0);
    deliver(16'h0000, 16'h7777, 1'b0);

    // Two redirects while squash pending: last target wins
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200);
    chk("dbl_addr_held", bus.imem_addr, 16'h0002);
    step(1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000);
    chk("dbl_ack_addr", bus.imem_addr, 16'h0002);
    idle();
    chk("dbl_target", bus.imem_addr, 16'h0200);
    deliver(16'h0200, 16'h0801, 1'b0);

    // Odd redirect target from HALT
    deliver(16'h0202, 16'h0000, 1'b0);
    idle();
    chk("halt2_req", {15'd0, bus.imem_req}, 16'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0021);
`ifdef FETCH_ALIGN_CHECK_EN
    idle();
    chk("align_err", {15'd0, err_fetch}, 16'd1);
    chk("align_req", {15'd0, bus.imem_req}, 16'd0);
    idle();
    chk("align_err_sticky", {15'd0, err_fetch}, 16'd1);
`else
    deliver(16'h0020, 16'h1200, 1'b0);
    chk("noalign_err", {15'd0, err_fetch}, 16'd0);
`endif

    // Reset mid-transaction
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("midrst_instr", instruction, 16'h0800);
    chk("midrst_pc_out", pc_out, 16'h0000);
    chk("midrst_done", {15'd0, done_fetch}, 16'd0);
    step(1'b1, 16'h5000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rel_instr", instruction, 16'h0800);
    idle();
    chk("rel_first_addr", bus.imem_addr, 16'h0000);
    chk("rel_first_req", {15'd0, bus.imem_req}, 16'd1);
    deliver(16'h0000, 16'h0900, 1'b0);
    repeat (3) idle();
    chk("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test expected finish before 100000");
    $fatal(1);
  end
endmodule
